// File: rtl/processor_pkg.sv
// Shared processor definitions used by the execute-stage multiply/divide unit:
// ALU opcodes that start the unit, the unit's FSM state encoding and its latency.
package processor_pkg;

    localparam logic [4:0] ALUOP_MULT = 5'b00110;
    localparam logic [4:0] ALUOP_DIV  = 5'b00111;

    localparam int MD_WIDTH   = 32;
    localparam int MD_LATENCY = MD_WIDTH + 2;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

endpackage

// File: rtl/multdiv_datapath.sv
// Shift/add datapath for the multiply/divide unit. One shared (2*WIDTH+1)-bit
// accumulator: radix-2 Booth product for MULT, {remainder, quotient} for DIV.
// One iteration per step; sequencing lives in multdiv_unit.
module multdiv_datapath
    import processor_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                       clock,
    input  logic                       load,
    input  logic                       load_div,
    input  logic                       step,
    input  logic                       div_mode,
    input  logic signed [WIDTH-1:0]    operand_a,
    input  logic signed [WIDTH-1:0]    operand_b,
    output logic signed [2*WIDTH-1:0]  product,
    output logic        [WIDTH-1:0]    quotient
);

    logic        [2*WIDTH:0]   acc_q;
    logic        [WIDTH-1:0]   opnd_q;

    logic signed [WIDTH-1:0]   booth_hi;
    logic signed [WIDTH:0]     booth_sum;
    logic        [WIDTH:0]     div_shift;
    logic        [WIDTH+1:0]   div_diff;

    // Two's-complement magnitude; the most negative value maps to 2**(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? WIDTH'(-v) : WIDTH'(v);
    endfunction

    // Booth add/sub in WIDTH+1 bits so the most negative multiplicand cannot wrap,
    // and the trial subtraction of the restoring divider.
    always_comb begin
        booth_hi  = $signed(acc_q[2*WIDTH:WIDTH+1]);
        booth_sum = {booth_hi[WIDTH-1], booth_hi};
        case (acc_q[1:0])
            2'b01:   booth_sum = {booth_hi[WIDTH-1], booth_hi} + {opnd_q[WIDTH-1], opnd_q};
            2'b10:   booth_sum = {booth_hi[WIDTH-1], booth_hi} - {opnd_q[WIDTH-1], opnd_q};
            default: booth_sum = {booth_hi[WIDTH-1], booth_hi};
        endcase
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
    end

    // Operand latch on start, then one Booth or restoring step per enable.
    always_ff @(posedge clock) begin
        if (load) begin
            if (load_div) begin
                opnd_q <= magnitude(operand_b);
                acc_q  <= {{(WIDTH+1){1'b0}}, magnitude(operand_a)};
            end else begin
                opnd_q <= operand_a;
                acc_q  <= {{WIDTH{1'b0}}, operand_b, 1'b0};
            end
        end else if (step) begin
            if (div_mode) begin
                if (!div_diff[WIDTH+1])
                    acc_q <= {div_diff[WIDTH:0], acc_q[WIDTH-2:0], 1'b1};
                else
                    acc_q <= {div_shift, acc_q[WIDTH-2:0], 1'b0};
            end else begin
                acc_q <= {booth_sum, acc_q[WIDTH:1]};
            end
        end
    end

    assign product  = $signed(acc_q[2*WIDTH:1]);
    assign quotient = acc_q[WIDTH-1:0];

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit for the execute stage.
// FSM IDLE -> RUN (WIDTH iterations) -> FIX (sign/exception, result load) -> DONE (RDY).
// Optional macro MULTDIV_EARLY_DIVZERO_EN: a DIV by zero skips straight to DONE.
module multdiv_unit
    import processor_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    md_state_e             state_q, state_d;
    logic [CNT_W-1:0]      count_q;
    logic                  div_q, neg_q, bzero_q, ovf_q;
    logic [WIDTH-1:0]      result_q;
    logic                  exc_q;

    logic                  start, start_div, accept, early_dz;
    logic signed [2*WIDTH-1:0] product;
    logic        [WIDTH-1:0]   quotient;

    // Apply the quotient sign: negate iff operand signs differed.
    function automatic logic [WIDTH-1:0] div_signed(input logic [WIDTH-1:0] q,
                                                    input logic neg);
        return neg ? WIDTH'(-q) : q;
    endfunction

    // Product overflows when its upper half is not the sign extension of the low half.
    function automatic logic mult_overflow(input logic signed [2*WIDTH-1:0] p);
        return p[2*WIDTH-1:WIDTH] != {WIDTH{p[WIDTH-1]}};
    endfunction

    assign start     = ctrl_MULT | ctrl_DIV;
    assign start_div = ctrl_DIV & ~ctrl_MULT;
    assign accept    = (state_q == MD_IDLE) && start;

`ifdef MULTDIV_EARLY_DIVZERO_EN
    assign early_dz = start_div && (data_operandB == '0);
`else
    assign early_dz = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state_q <= MD_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: if (start) state_d = early_dz ? MD_DONE : MD_RUN;
            MD_RUN:  if (count_q == CNT_W'(WIDTH - 1)) state_d = MD_FIX;
            MD_FIX:  state_d = MD_DONE;
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    // Iteration counter and the per-operation flags captured at start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            bzero_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            count_q <= '0;
            div_q   <= start_div;
            neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            bzero_q <= (data_operandB == '0);
            ovf_q   <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                       (data_operandB == '1);
        end else if (state_q == MD_RUN) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Result/exception register: loaded in FIX (or on an early divide-by-zero), held otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result_q <= '0;
            exc_q    <= 1'b0;
        end else if (state_q == MD_FIX) begin
            if (div_q) begin
                result_q <= bzero_q ? '0 : div_signed(quotient, neg_q);
                exc_q    <= bzero_q | ovf_q;
            end else begin
                result_q <= product[WIDTH-1:0];
                exc_q    <= mult_overflow(product);
            end
        end else if (accept && early_dz) begin
            result_q <= '0;
            exc_q    <= 1'b1;
        end
    end

    multdiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clock     (clock),
        .load      (accept),
        .load_div  (start_div),
        .step      (state_q == MD_RUN),
        .div_mode  (div_q),
        .operand_a ($signed(data_operandA)),
        .operand_b ($signed(data_operandB)),
        .product   (product),
        .quotient  (quotient)
    );

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == MD_DONE);
    assign busy           = (state_q != MD_IDLE);

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed testbench for multdiv_unit. Cycle n is the clock period following
// start edge n-1; the start is sampled at edge 0, so the first sample is cycle 1.
module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_operandA, data_operandB;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY, busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] res;
    logic        exc;
    int          rdy_cycle, rdy_count, busy_first, busy_last;
    int          exp_dz_cycle;

    multdiv_unit #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one start, then watch 72 cycles. Optional second start (inj_*) at cycle inj,
    // optional reset pulse beginning at cycle rst_cycle (0 disables either).
    task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                          input int inj, input logic im, input logic id,
                          input logic [31:0] ia, input logic [31:0] ib, input int rst_cycle);
        res = '0; exc = 1'b0;
        rdy_cycle = 0; rdy_count = 0; busy_first = 0; busy_last = 0;
        @(negedge clock);
        ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        for (int n = 1; n <= 72; n++) begin
            if (n == rst_cycle) begin
                reset_n = 1'b0;
                #1;
                check("reset_mid_op_outputs",
                      {data_result, data_exception, data_resultRDY, busy}, 64'd0);
            end
            if (n == rst_cycle + 2) reset_n = 1'b1;
            if (busy) begin
                if (busy_first == 0) busy_first = n;
                busy_last = n;
            end
            if (data_resultRDY) begin
                rdy_count++;
                if (rdy_count == 1) rdy_cycle = n;
                res = data_result;
                exc = data_exception;
            end
            if (n == inj) begin
                ctrl_MULT = im; ctrl_DIV = id; data_operandA = ia; data_operandB = ib;
            end else if (n == inj + 1) begin
                ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
            end
            @(posedge clock); #1;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = '0; data_operandB = '0;
`ifdef MULTDIV_EARLY_DIVZERO_EN
        exp_dz_cycle = 1;
`else
        exp_dz_cycle = 34;
`endif
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", {data_result, data_exception, data_resultRDY, busy}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // MULT 7 * -3 with full timing
        run_op(1, 0, 32'd7, 32'hFFFF_FFFD, 0, 0, 0, 0, 0, 0);
        check("mul_7x-3_result", res, 32'hFFFF_FFEB);
        check("mul_7x-3_exc", exc, 1'b0);
        check("mul_rdy_cycle", rdy_cycle, 34);
        check("mul_rdy_count", rdy_count, 1);
        check("mul_busy_first", busy_first, 1);
        check("mul_busy_last", busy_last, 34);

        run_op(1, 0, 32'h4000_0000, 32'd2, 0, 0, 0, 0, 0, 0);
        check("mul_ovf_result", res, 32'h8000_0000);
        check("mul_ovf_exc", exc, 1'b1);

        run_op(1, 0, 32'h0001_0000, 32'h0001_0000, 0, 0, 0, 0, 0, 0);
        check("mul_2p32_result", res, 32'h0);
        check("mul_2p32_exc", exc, 1'b1);

        run_op(0, 1, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0, 0, 0);
        check("div_-7/2_result", res, 32'hFFFF_FFFD);
        check("div_-7/2_exc", exc, 1'b0);
        check("div_rdy_cycle", rdy_cycle, 34);

        run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
        check("div_min/-1_result", res, 32'h8000_0000);
        check("div_min/-1_exc", exc, 1'b1);

        run_op(0, 1, 32'd5, 32'd0, 0, 0, 0, 0, 0, 0);
        check("div_by0_result", res, 32'h0);
        check("div_by0_exc", exc, 1'b1);
        check("div_by0_rdy_cycle", rdy_cycle, exp_dz_cycle);
        check("div_by0_busy_last", busy_last, exp_dz_cycle);

        // DIV 100/5 presented in cycle 10 of a running MULT is ignored
        run_op(1, 0, 32'd7, 32'hFFFF_FFFD, 10, 0, 1, 32'd100, 32'd5, 0);
        check("busy_start_rdy_count", rdy_count, 1);
        check("busy_start_result", res, 32'hFFFF_FFEB);

        // Start in the DONE cycle is ignored
        run_op(0, 1, 32'hFFFF_FFF9, 32'd2, 34, 1, 0, 32'd9, 32'd9, 0);
        check("done_start_rdy_count", rdy_count, 1);
        check("done_start_result", res, 32'hFFFF_FFFD);

        // Start on the cycle after DONE is accepted
        run_op(1, 0, 32'd6, 32'd7, 35, 1, 0, 32'd3, 32'd5, 0);
        check("after_done_rdy_count", rdy_count, 2);
        check("after_done_result", res, 32'd15);

        // Reset low in cycle 15 aborts the operation
        run_op(1, 0, 32'h4000_0000, 32'd2, 0, 0, 0, 0, 0, 15);
        check("reset_abort_rdy_count", rdy_count, 0);

        run_op(1, 0, 32'd3, 32'd4, 0, 0, 0, 0, 0, 0);
        check("post_reset_mul_result", res, 32'd12);
        check("post_reset_mul_exc", exc, 1'b0);

        // Both start bits high: treated as MULT
        run_op(1, 1, 32'd6, 32'd3, 0, 0, 0, 0, 0, 0);
        check("both_start_result", res, 32'd18);
        check("both_start_exc", exc, 1'b0);
        check("result_hold", data_result, 32'd18);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
